gb_timer: RTL and testbench
===========================

GB_TIMER -- requirements
Module: gb_timer

Interface
REQ-001 SHALL have clock and reset: one clock; reset is asynchronous and active-high.
REQ-002 SHALL have port `clk`, input, 1 bit: clock; one rising edge = one M-cycle of the core.
REQ-003 SHALL have port `rst`, input, 1 bit: asynchronous active-high reset.
REQ-004 SHALL have port `addr`, input, addr_t (16 bits): bus address, driven by the core's w_addr/r_addr (identical in the core).
REQ-005 SHALL have port `w_data`, input, data_t (8 bits): write data from the core.
REQ-006 SHALL have port `w_wen`, input, 1 bit: write strobe; sampled on `clk` rising edge.
REQ-007 SHALL have port `r_data`, output, data_t (8 bits): combinational read data; 8'hFF when `r_hit`=0.
REQ-008 SHALL have port `r_hit`, output, 1 bit: combinational; 1 when `addr` is in FF04..FF07; used by the bus mux.
REQ-009 SHALL have port `irq`, output, 1 bit: registered one-cycle timer-interrupt request pulse, for IF bit 2.

Function
REQ-010 SHALL keep a 14-bit free-running counter `sys_cnt`, incremented by 1 every cycle and wrapping 3FFF->0000.
REQ-011 SHALL return DIV (FF04) reads as sys_cnt[13:6].
REQ-012 SHALL clear sys_cnt to 0 on any write to FF04; w_data is ignored.
REQ-013 SHALL return TIMA (FF05) and TMA (FF06) reads as their 8-bit values.
REQ-014 SHALL return TAC (FF07) reads as {5'b11111, tac[2:0]}; writes store w_data[2:0].
REQ-015 SHALL select the tap bit from TAC[1:0]: 00->sys_cnt[7] (256 cycles), 01->bit[1] (4), 10->bit[3] (16), 11->bit[5] (64).
REQ-016 SHALL register tick_sig = TAC[2] & tap each cycle, and SHALL increment TIMA on a 1->0 transition of tick_sig.
REQ-017 SHALL therefore increment TIMA on a falling transition caused by a DIV reset, a TAC enable clear, or a TAC select change (hardware-accurate glitch).
REQ-018 SHALL run a 3-state FSM: IDLE, OVF (TIMA reads 00), RELOAD.
REQ-019 SHALL move IDLE->OVF when a TIMA increment wraps FF->00.
REQ-020 SHALL move OVF->RELOAD on the next cycle; on that edge TIMA<=TMA and irq<=1 for exactly one cycle.
REQ-021 SHALL move RELOAD->IDLE unconditionally.
REQ-022 In OVF, a CPU write to TIMA SHALL cancel the reload and irq; TIMA takes w_data and the FSM returns to IDLE.
REQ-023 In RELOAD, a CPU write to TIMA SHALL be ignored (TMA value wins).
REQ-024 In RELOAD, a write to TMA SHALL also load the new value into TIMA.
REQ-025 On a same-cycle CPU write to TIMA and an increment in IDLE, the write SHALL win and the increment is dropped.
REQ-026 SHALL give writes effect at the clock edge; a read in the same cycle returns the old value.

Reset
REQ-027 While rst=1: sys_cnt=0, TIMA=0, TMA=0, TAC=0, tick_sig=0, FSM=IDLE, irq=0.
REQ-028 r_data/r_hit SHALL remain purely address-decoded during reset; a pending overflow is discarded.

Structure
REQ-029 sm83_pkg SHALL add constants ADDR_DIV/ADDR_TIMA/ADDR_TMA/ADDR_TAC, tac_t (packed: enable, sel[1:0]) and timer_state_t enum.
REQ-030 SHALL be single flat module; no sub-module required (edge detect is inline).

Verification
REQ-031 Bench SHALL cover: TAC=3'b101, TIMA=0 -> TIMA=1 after 4 cycles, =4 after 16.
REQ-032 Bench SHALL cover: TMA=8'h80, TIMA=8'hFF, TAC=3'b101 -> TIMA reads 00 one cycle, then 80; irq high exactly 1 cycle.
REQ-033 Bench SHALL cover: write TIMA=8'h10 during OVF cycle -> TIMA=10, irq never asserts.
REQ-034 Bench SHALL cover: TAC=3'b100, sys_cnt[7]=1, write FF04 -> DIV=00 and TIMA increments by 1.
REQ-035 Bench SHALL cover: assert rst mid-OVF -> all registers 0, irq=0, FF07 reads F8; read FF08 -> r_hit=0, r_data=FF.

Source files
------------

// File: rtl/sm83_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package    : sm83_pkg                                                      |
// | Purpose    : Shared bus types, timer register addresses and timer types    |
// |              used by the SM83 core peripherals.                            |
// | Contents   : addr_t / data_t bus types, ADDR_DIV..ADDR_TAC, tac_t,         |
// |              timer_state_t, tap_bit() helper.                              |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package sm83_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  localparam addr_t ADDR_DIV  = 16'hFF04;
  localparam addr_t ADDR_TIMA = 16'hFF05;
  localparam addr_t ADDR_TMA  = 16'hFF06;
  localparam addr_t ADDR_TAC  = 16'hFF07;

  // Timer control register as stored: enable in bit 2, clock select in [1:0].
  typedef struct packed {
    logic       enable;
    logic [1:0] sel;
  } tac_t;

  typedef enum logic [1:0] {
    TS_IDLE   = 2'd0,
    TS_OVF    = 2'd1,
    TS_RELOAD = 2'd2
  } timer_state_t;

  // Index of the free-running counter bit whose falling edge clocks TIMA.
  function automatic logic [2:0] tap_bit(input logic [1:0] sel);
    logic [2:0] idx;
    idx = 3'd7;
    case (sel)
      2'b00:   idx = 3'd7;
      2'b01:   idx = 3'd1;
      2'b10:   idx = 3'd3;
      default: idx = 3'd5;
    endcase
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/gb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : gb_timer                                                      |
// | Purpose    : DIV/TIMA/TMA/TAC timer block with overflow-reload sequencing  |
// |              and the falling-edge increment glitches of the original part. |
// | Ports      : clk     - clock, one rising edge per M-cycle                  |
// |              rst     - asynchronous active-high reset                      |
// |              addr    - bus address (shared read/write)                     |
// |              w_data  - write data                                          |
// |              w_wen   - write strobe                                        |
// |              r_data  - combinational read data, FF when not hit            |
// |              r_hit   - addr decodes to FF04..FF07                          |
// |              irq     - one-cycle timer interrupt request (IF bit 2)        |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module gb_timer
  import sm83_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] addr,
  input  logic [7:0]  w_data,
  input  logic        w_wen,
  output logic [7:0]  r_data,
  output logic        r_hit,
  output logic        irq
);

  logic [13:0]  sys_cnt_q;
  logic [13:0]  sys_cnt_d;
  logic [7:0]   tima_q;
  logic [7:0]   tma_q;
  tac_t         tac_q;
  logic         tick_q;
  logic         tick_d;
  timer_state_t state_q;
  logic         irq_q;

  logic w_wr_div;
  logic w_wr_tima;
  logic w_wr_tma;
  logic w_wr_tac;
  logic w_tick_fall;

  assign w_wr_div  = w_wen && (addr == ADDR_DIV);
  assign w_wr_tima = w_wen && (addr == ADDR_TIMA);
  assign w_wr_tma  = w_wen && (addr == ADDR_TMA);
  assign w_wr_tac  = w_wen && (addr == ADDR_TAC);

  assign sys_cnt_d = w_wr_div ? 14'd0 : sys_cnt_q + 14'd1;

  // The increment is an edge detector on (enable & tap), not a divider.
  // Anything that pulls this term low -- counter clear, enable clear or a
  // select change -- therefore produces an extra TIMA tick.
  assign tick_d      = tac_q.enable & sys_cnt_q[tap_bit(tac_q.sel)];
  assign w_tick_fall = tick_q & ~tick_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sys_cnt_q <= 14'd0;
      tma_q     <= 8'h00;
      tac_q     <= '0;
      tick_q    <= 1'b0;
    end else begin
      sys_cnt_q <= sys_cnt_d;
      tick_q    <= tick_d;
      if (w_wr_tma) tma_q <= w_data;
      if (w_wr_tac) tac_q <= w_data[2:0];
    end
  end

  // Overflow sequencing: TIMA sits at 00 for one cycle (OVF) before the
  // reload from TMA and the interrupt pulse; RELOAD is the cycle after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TS_IDLE;
      tima_q  <= 8'h00;
      irq_q   <= 1'b0;
    end else begin
      irq_q <= 1'b0;
      case (state_q)
        TS_OVF: begin
          if (w_wr_tima) begin
            // A CPU write in the 00 window aborts the reload and the irq.
            tima_q  <= w_data;
            state_q <= TS_IDLE;
          end else begin
            tima_q  <= tma_q;
            irq_q   <= 1'b1;
            state_q <= TS_RELOAD;
          end
        end
        TS_RELOAD: begin
          // TIMA is still tracking TMA here, so a TMA write lands in both
          // and a TIMA write is lost.
          if (w_wr_tma) tima_q <= w_data;
          state_q <= TS_IDLE;
        end
        default: begin
          if (w_wr_tima) begin
            tima_q <= w_data;
          end else if (w_tick_fall) begin
            tima_q <= tima_q + 8'd1;
            if (tima_q == 8'hFF) state_q <= TS_OVF;
          end
          if (state_q != TS_IDLE) state_q <= TS_IDLE;
        end
      endcase
    end
  end

  assign irq = irq_q;

  always_comb begin
    r_hit  = 1'b0;
    r_data = 8'hFF;
    case (addr)
      ADDR_DIV:  begin r_hit = 1'b1; r_data = sys_cnt_q[13:6];         end
      ADDR_TIMA: begin r_hit = 1'b1; r_data = tima_q;                  end
      ADDR_TMA:  begin r_hit = 1'b1; r_data = tma_q;                   end
      ADDR_TAC:  begin r_hit = 1'b1; r_data = {5'b11111, tac_q};       end
      default:   begin r_hit = 1'b0; r_data = 8'hFF;                   end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_gb_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module     : tb_gb_timer                                                   |
// | Purpose    : Self-checking bench for gb_timer: a cycle-level reference     |
// |              model compared on every falling clock edge, plus directed     |
// |              scenarios with hand-computed register values.                 |
// | Revision   : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_gb_timer;

  localparam logic [15:0] A_DIV  = 16'hFF04;
  localparam logic [15:0] A_TIMA = 16'hFF05;
  localparam logic [15:0] A_TMA  = 16'hFF06;
  localparam logic [15:0] A_TAC  = 16'hFF07;
  localparam logic [15:0] A_NONE = 16'hFF08;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] addr;
  logic [7:0]  w_data;
  logic        w_wen;
  logic [7:0]  r_data;
  logic        r_hit;
  logic        irq;

  int n_vec  = 0;
  int n_fail = 0;

  gb_timer dut (
    .clk    (clk),
    .rst    (rst),
    .addr   (addr),
    .w_data (w_data),
    .w_wen  (w_wen),
    .r_data (r_data),
    .r_hit  (r_hit),
    .irq    (irq)
  );

  always #10 clk = ~clk;

  // ---------------- reference model ----------------
  // Plain integer view of the timer: a cycle counter, the three registers,
  // the last sampled "enabled tap" level and a phase number for the
  // overflow sequence (0 normal, 1 reads-00 window, 2 reload cycle).
  int m_cnt, m_tima, m_tma, m_tac, m_phase;
  int m_prev, m_irq;
  int tapbit [4] = '{7, 1, 3, 5};
  int s_tap, s_fall, s_div, s_tima, s_tma, s_tac;

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_cnt = 0; m_tima = 0; m_tma = 0; m_tac = 0;
      m_phase = 0; m_prev = 0; m_irq = 0;
    end else begin
      s_div  = (w_wen && addr == A_DIV)  ? 1 : 0;
      s_tima = (w_wen && addr == A_TIMA) ? 1 : 0;
      s_tma  = (w_wen && addr == A_TMA)  ? 1 : 0;
      s_tac  = (w_wen && addr == A_TAC)  ? 1 : 0;
      s_tap  = ((m_tac >> 2) & 1) & ((m_cnt >> tapbit[m_tac & 3]) & 1);
      s_fall = (m_prev == 1 && s_tap == 0) ? 1 : 0;
      m_prev = s_tap;
      m_irq  = 0;
      if (m_phase == 1) begin
        if (s_tima != 0) begin
          m_tima  = int'(w_data);
          m_phase = 0;
        end else begin
          m_tima  = m_tma;
          m_irq   = 1;
          m_phase = 2;
        end
      end else if (m_phase == 2) begin
        if (s_tma != 0) m_tima = int'(w_data);
        m_phase = 0;
      end else begin
        if (s_tima != 0) m_tima = int'(w_data);
        else if (s_fall != 0) begin
          m_tima = m_tima + 1;
          if (m_tima == 256) begin
            m_tima  = 0;
            m_phase = 1;
          end
        end
      end
      m_cnt = (s_div != 0) ? 0 : (m_cnt + 1) % 16384;
      if (s_tma != 0) m_tma = int'(w_data);
      if (s_tac != 0) m_tac = int'(w_data) & 7;
    end
  end

  function automatic int exp_data(input logic [15:0] a);
    case (a)
      A_DIV:   return (m_cnt / 64) % 256;
      A_TIMA:  return m_tima;
      A_TMA:   return m_tma;
      A_TAC:   return 8'hF8 + m_tac;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic int exp_hit(input logic [15:0] a);
    return (a >= A_DIV && a <= A_TAC) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_vec = n_vec + 1;
    if (act !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("bus_hit",  16'(r_hit),  16'(exp_hit(addr)));
    chk("bus_data", 16'(r_data), 16'(exp_data(addr)));
    chk("irq",      16'(irq),    16'(m_irq));
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input logic [15:0] a, input logic [7:0] d, input logic we);
    addr = a; w_data = d; w_wen = we;
    @(posedge clk); #1;
    w_wen = 1'b0;
  endtask

  task automatic idle(input int n);
    addr = A_TIMA; w_wen = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [15:0] a, input logic [7:0] exp);
    addr = a; w_wen = 1'b0;
    #1;
    chk(nm, 16'(r_data), 16'(exp));
  endtask

  // Leaves the timer in the reads-00 overflow window with TMA=80.
  task automatic overflow_setup(input string tag);
    cyc(A_TAC, 8'h00, 1'b1);
    cyc(A_DIV, 8'h5A, 1'b1);     // counter = 0
    cyc(A_TMA, 8'h80, 1'b1);
    cyc(A_TIMA, 8'hFF, 1'b1);
    cyc(A_TAC, 8'h05, 1'b1);     // counter = 3, enabled, 4-cycle tap
    idle(1);                     // counter = 4: tap falls
    lit({tag, "_pre"}, A_TIMA, 8'hFF);
    idle(1);                     // increment lands, FF -> 00
    lit({tag, "_ovf00"}, A_TIMA, 8'h00);
    chk({tag, "_ovf_irq"}, 16'(irq), 16'h0);
  endtask

  initial begin
    rst = 1'b1; addr = A_TIMA; w_data = 8'h00; w_wen = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    lit("rst_tac", A_TAC, 8'hF8);
    lit("rst_div", A_DIV, 8'h00);
    chk("rst_irq", 16'(irq), 16'h0);
    rst = 1'b0;

    // Enabled 4-cycle tap from a cleared counter.
    cyc(A_TAC, 8'h00, 1'b1);
    cyc(A_DIV, 8'h00, 1'b1);
    cyc(A_TAC, 8'h05, 1'b1);
    cyc(A_TIMA, 8'h00, 1'b1);
    idle(2);  lit("inc_at3",  A_TIMA, 8'h00);
    idle(1);  lit("inc_at4",  A_TIMA, 8'h01);
    idle(11); lit("inc_at15", A_TIMA, 8'h03);
    idle(1);  lit("inc_at16", A_TIMA, 8'h04);

    // Normal overflow: 00 for one cycle, then TMA, irq for one cycle.
    overflow_setup("ovf");
    idle(1);
    lit("ovf_reload", A_TIMA, 8'h80);
    chk("ovf_irq_on", 16'(irq), 16'h1);
    idle(1);
    chk("ovf_irq_off", 16'(irq), 16'h0);
    lit("ovf_after", A_TIMA, 8'h80);

    // CPU write in the 00 window cancels reload and irq.
    overflow_setup("cxl");
    cyc(A_TIMA, 8'h10, 1'b1);
    lit("cxl_tima", A_TIMA, 8'h10);
    chk("cxl_irq", 16'(irq), 16'h0);
    idle(1);
    chk("cxl_irq2", 16'(irq), 16'h0);

    // TIMA write during the reload cycle is lost.
    overflow_setup("rlw");
    idle(1);
    cyc(A_TIMA, 8'h33, 1'b1);
    lit("rlw_tima", A_TIMA, 8'h80);

    // TMA write during the reload cycle also lands in TIMA.
    overflow_setup("rlm");
    idle(1);
    cyc(A_TMA, 8'h44, 1'b1);
    lit("rlm_tima", A_TIMA, 8'h44);
    lit("rlm_tma",  A_TMA,  8'h44);

    // Clearing DIV while the 256-cycle tap is high ticks TIMA once.
    cyc(A_TAC, 8'h00, 1'b1);
    cyc(A_DIV, 8'h00, 1'b1);
    cyc(A_TIMA, 8'h20, 1'b1);
    cyc(A_TAC, 8'h04, 1'b1);
    idle(128);
    lit("glt_div_pre", A_DIV, 8'h02);
    cyc(A_DIV, 8'hC3, 1'b1);
    lit("glt_div", A_DIV, 8'h00);
    lit("glt_tima0", A_TIMA, 8'h20);
    idle(1);
    lit("glt_tima1", A_TIMA, 8'h21);

    // Reset in the overflow window discards everything.
    overflow_setup("rov");
    rst = 1'b1;
    #1;
    lit("rov_tima", A_TIMA, 8'h00);
    lit("rov_tma",  A_TMA,  8'h00);
    lit("rov_div",  A_DIV,  8'h00);
    lit("rov_tac",  A_TAC,  8'hF8);
    chk("rov_irq", 16'(irq), 16'h0);
    addr = A_NONE;
    #1;
    chk("rov_nohit", 16'(r_hit), 16'h0);
    chk("rov_ff",    16'(r_data), 16'h00FF);
    @(posedge clk); #1;
    chk("rov_irq_edge", 16'(irq), 16'h0);
    rst = 1'b0;
    idle(3);
    lit("rov_tima_after", A_TIMA, 8'h00);

    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
